// File: rtl/hilo_div_ctrl_if.sv
// Signal bundle between the HI/LO divide controller and its neighbours:
// the EX stage (request + MTHI/MTLO), the iterative divider, and the
// pipeline stall/result logic.
//
// Request handshake: a request transfers on a rising div_clk edge where
// req_valid and req_ready are both 1. The requester holds req_* stable
// while req_valid=1 and req_ready=0. req_ready is combinational from
// the controller state. It does not depend on req_valid.
interface hilo_div_ctrl_if;
    logic        req_valid;
    logic        req_signed;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic        req_ready;
    logic        cancel;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        div;
    logic        div_signed;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] s;
    logic [31:0] r;
    logic        complete;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        dz;
    logic        tmo;
    logic [1:0]  dbg_state;

    // Controller side.
    modport slave (
        input  req_valid, req_signed, req_x, req_y, cancel,
        input  mthi, mtlo, wdata, s, r, complete,
        output req_ready, div, div_signed, x, y,
        output hi, lo, busy, done, dz, tmo, dbg_state
    );

    // Environment side: EX stage, divider and pipeline control.
    modport master (
        output req_valid, req_signed, req_x, req_y, cancel,
        output mthi, mtlo, wdata, s, r, complete,
        input  req_ready, div, div_signed, x, y,
        input  hi, lo, busy, done, dz, tmo, dbg_state
    );
endinterface

// File: rtl/hilo_div_ctrl.sv
// HI/LO divide controller. It accepts a DIV/DIVU request from EX and
// launches the external divider with a one-cycle start pulse. It then
// waits a bounded time for the result and writes the remainder to HI
// and the quotient to LO. A divisor of zero is reported without
// launching. The wait ends early on a pipeline flush. MTHI/MTLO writes
// go through only while the controller is idle.
module hilo_div_ctrl (
    input  logic            div_clk,
    input  logic            reset,
    hilo_div_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt;
    logic        accept;
    logic        zero_div;
    logic        write_res;
    logic        timeout;

    logic        div_q, div_signed_q, done_q, dz_q, tmo_q;
    logic [31:0] x_q, y_q, hi_q, lo_q;

    // State register.
    always_ff @(posedge div_clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and per-edge event strobes. A flush beats a
    // completing result. A result arriving on the last wait cycle beats
    // the timeout.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        zero_div  = 1'b0;
        write_res = 1'b0;
        timeout   = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.req_valid && !bus.cancel) begin
                    if (bus.req_y != 32'd0) begin
                        accept    = 1'b1;
                        state_nxt = S_LAUNCH;
                    end else begin
                        zero_div  = 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                state_nxt = S_WAIT;
                if (bus.cancel) state_nxt = S_IDLE;
            end
            S_WAIT: begin
                if (bus.cancel) begin
                    state_nxt = S_IDLE;
                end else if (bus.complete) begin
                    write_res = 1'b1;
                    state_nxt = S_IDLE;
                end else if (wait_cnt == 4'd15) begin
                    timeout   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Wait-cycle counter: cleared while launching, counts during the wait.
    always_ff @(posedge div_clk or posedge reset) begin
        if (reset)                 wait_cnt <= 4'd0;
        else if (state == S_LAUNCH) wait_cnt <= 4'd0;
        else if (state == S_WAIT)   wait_cnt <= wait_cnt + 4'd1;
    end

    // Divider operands are captured on acceptance and held until the next
    // acceptance. The start pulse therefore lines up exactly with LAUNCH.
    always_ff @(posedge div_clk or posedge reset) begin
        if (reset) begin
            div_q        <= 1'b0;
            div_signed_q <= 1'b0;
            x_q          <= 32'd0;
            y_q          <= 32'd0;
        end else begin
            div_q <= accept;
            if (accept) begin
                div_signed_q <= bus.req_signed;
                x_q          <= bus.req_x;
                y_q          <= bus.req_y;
            end
        end
    end

    // HI/LO: a divider result is written in WAIT only. MTHI/MTLO writes
    // happen in IDLE only, so the two sources never collide.
    always_ff @(posedge div_clk or posedge reset) begin
        if (reset) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (write_res) begin
            hi_q <= bus.r;
            lo_q <= bus.s;
        end else if (state == S_IDLE) begin
            if (bus.mthi) hi_q <= bus.wdata;
            if (bus.mtlo) lo_q <= bus.wdata;
        end
    end

    // One-cycle status pulses.
    always_ff @(posedge div_clk or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            done_q <= write_res | zero_div;
            dz_q   <= zero_div;
            tmo_q  <= timeout;
        end
    end

    assign bus.req_ready  = (state == S_IDLE);
    assign bus.busy       = (state != S_IDLE);
    assign bus.div        = div_q;
    assign bus.div_signed = div_signed_q;
    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.hi         = hi_q;
    assign bus.lo         = lo_q;
    assign bus.done       = done_q;
    assign bus.dz         = dz_q;
    assign bus.tmo        = tmo_q;
    assign bus.dbg_state  = state;

endmodule
